// File: rtl/load_port.sv
// load_port: issues load addresses to the memory interface and returns read
// data to the circuit in order. A credit counter bounds the in-flight loads
// so every issued request always has a free slot waiting in the return FIFO.
module load_port #(
  parameter int DATA_TYPE = 32,
  parameter int ADDR_TYPE = 32,
  parameter int NUM_SLOTS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_TYPE-1:0] addrIn,
  input  logic                 addrIn_valid,
  output logic                 addrIn_ready,
  output logic [ADDR_TYPE-1:0] addrOut,
  output logic                 addrOut_valid,
  input  logic                 addrOut_ready,
  input  logic [DATA_TYPE-1:0] dataFromMem,
  input  logic                 dataFromMem_valid,
  output logic                 dataFromMem_ready,
  output logic [DATA_TYPE-1:0] dataOut,
  output logic                 dataOut_valid,
  input  logic                 dataOut_ready
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CNT_W-1:0] SLOTS    = CNT_W'(NUM_SLOTS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);

  // Address register
  logic [ADDR_TYPE-1:0] r_addr_q;
  logic                 r_addr_full;

  // Credits: loads accepted but not yet handed back to the circuit
  logic [CNT_W-1:0]     r_cnt;

  // Return FIFO
  logic [DATA_TYPE-1:0] r_fifo [NUM_SLOTS];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_occ;

  logic w_credit_ok;
  logic w_load_en;
  logic w_addr_in_xfer;
  logic w_addr_out_xfer;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_enq;
  logic w_deq;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // No same-cycle credit bypass: a credit freed this cycle is usable next cycle.
  assign w_credit_ok     = (r_cnt < SLOTS);
  assign w_load_en       = (!r_addr_full || addrOut_ready) && w_credit_ok;
  assign addrIn_ready    = w_load_en && !rst;
  assign w_addr_in_xfer  = addrIn_valid && addrIn_ready;
  assign w_addr_out_xfer = r_addr_full && addrOut_ready;
  assign addrOut         = r_addr_q;
  assign addrOut_valid   = r_addr_full;

  assign w_fifo_full       = (r_occ == SLOTS);
  assign w_fifo_empty      = (r_occ == '0);
  assign dataFromMem_ready = !w_fifo_full && !rst;
  assign w_enq             = dataFromMem_valid && dataFromMem_ready;
  assign w_deq             = !w_fifo_empty && dataOut_ready;
  assign dataOut           = r_fifo[r_rd_ptr];
  assign dataOut_valid     = !w_fifo_empty;

  // Address register: load a new address, or drain when the interface takes it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_q    <= '0;
      r_addr_full <= 1'b0;
    end else if (w_addr_in_xfer) begin
      r_addr_q    <= addrIn;
      r_addr_full <= 1'b1;
    end else if (w_addr_out_xfer) begin
      r_addr_full <= 1'b0;
    end
  end

  // Credit counter: +1 per accepted address, -1 per result delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_addr_in_xfer && !w_deq) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (!w_addr_in_xfer && w_deq) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // FIFO control: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= f_next_ptr(r_wr_ptr);
      if (w_deq) r_rd_ptr <= f_next_ptr(r_rd_ptr);
      if (w_enq && !w_deq)      r_occ <= r_occ + CNT_W'(1);
      else if (!w_enq && w_deq) r_occ <= r_occ - CNT_W'(1);
    end
  end

  // FIFO storage: write the returning read data at the tail.
  // NOTE: the entries are reset because the head is visible on dataOut right
  // after reset and must read as zero; this forces flops rather than a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_fifo[i] <= '0;
    end else if (w_enq) begin
      r_fifo[r_wr_ptr] <= dataFromMem;
    end
  end

  // Read data with no load outstanding is illegal stimulus.
  a_no_unsolicited_data : assert property (
    @(posedge clk) disable iff (rst) !(dataFromMem_valid && (r_cnt == '0))
  );

endmodule

// File: tb/tb_load_port.sv
// Directed bench for load_port: one instance with two slots for most tests
// and one with three slots for the wrap-around test.
module tb_load_port;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Two-slot instance
  logic [31:0] a_addr_in, a_addr_out, a_mem_data, a_data_out;
  logic        a_addr_in_valid, a_addr_in_ready, a_addr_out_valid, a_addr_out_ready;
  logic        a_mem_valid, a_mem_ready, a_data_out_valid, a_data_out_ready;

  // Three-slot instance
  logic [31:0] b_addr_in, b_addr_out, b_mem_data, b_data_out;
  logic        b_addr_in_valid, b_addr_in_ready, b_addr_out_valid, b_addr_out_ready;
  logic        b_mem_valid, b_mem_ready, b_data_out_valid, b_data_out_ready;

  load_port #(.DATA_TYPE(32), .ADDR_TYPE(32), .NUM_SLOTS(2)) dut2 (
    .clk(clk), .rst(rst),
    .addrIn(a_addr_in), .addrIn_valid(a_addr_in_valid), .addrIn_ready(a_addr_in_ready),
    .addrOut(a_addr_out), .addrOut_valid(a_addr_out_valid), .addrOut_ready(a_addr_out_ready),
    .dataFromMem(a_mem_data), .dataFromMem_valid(a_mem_valid), .dataFromMem_ready(a_mem_ready),
    .dataOut(a_data_out), .dataOut_valid(a_data_out_valid), .dataOut_ready(a_data_out_ready)
  );

  load_port #(.DATA_TYPE(32), .ADDR_TYPE(32), .NUM_SLOTS(3)) dut3 (
    .clk(clk), .rst(rst),
    .addrIn(b_addr_in), .addrIn_valid(b_addr_in_valid), .addrIn_ready(b_addr_in_ready),
    .addrOut(b_addr_out), .addrOut_valid(b_addr_out_valid), .addrOut_ready(b_addr_out_ready),
    .dataFromMem(b_mem_data), .dataFromMem_valid(b_mem_valid), .dataFromMem_ready(b_mem_ready),
    .dataOut(b_data_out), .dataOut_valid(b_data_out_valid), .dataOut_ready(b_data_out_ready)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] nxt;
  int issued, results, window, sent, got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well before the next edge.
  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    a_addr_in = '0; a_addr_in_valid = 1'b0; a_addr_out_ready = 1'b1;
    a_mem_data = '0; a_mem_valid = 1'b0; a_data_out_ready = 1'b0;
    b_addr_in = '0; b_addr_in_valid = 1'b0; b_addr_out_ready = 1'b1;
    b_mem_data = '0; b_mem_valid = 1'b0; b_data_out_ready = 1'b0;

    // ---- reset ----
    step; step;
    settle;
    check("rst in_ready low", 32'(a_addr_in_ready), 0);
    check("rst mem_ready low", 32'(a_mem_ready), 0);
    step;
    rst = 1'b0;
    settle;
    check("rst addr_out_valid", 32'(a_addr_out_valid), 0);
    check("rst data_out_valid", 32'(a_data_out_valid), 0);
    check("rst addr_out", a_addr_out, 0);
    check("rst data_out", a_data_out, 0);
    check("rst in_ready", 32'(a_addr_in_ready), 1);
    check("rst mem_ready", 32'(a_mem_ready), 1);

    // ---- single load ----
    a_addr_in = 32'h10; a_addr_in_valid = 1'b1;
    settle;
    check("t1 in_ready", 32'(a_addr_in_ready), 1);
    check("t1 no comb path addr", 32'(a_addr_out_valid), 0);
    step; a_addr_in_valid = 1'b0; settle;
    check("t1 addr_out_valid", 32'(a_addr_out_valid), 1);
    check("t1 addr_out", a_addr_out, 32'h10);
    step; settle;
    check("t1 addr drained", 32'(a_addr_out_valid), 0);
    step; a_mem_data = 32'hCAFE; a_mem_valid = 1'b1; settle;
    check("t1 mem_ready", 32'(a_mem_ready), 1);
    check("t1 no comb path data", 32'(a_data_out_valid), 0);
    step; a_mem_valid = 1'b0; a_data_out_ready = 1'b1; settle;
    check("t1 data_out_valid", 32'(a_data_out_valid), 1);
    check("t1 data_out", a_data_out, 32'hCAFE);
    step; a_data_out_ready = 1'b0; settle;
    check("t1 fifo empty", 32'(a_data_out_valid), 0);

    // ---- credit stall ----
    step; a_addr_in = 32'h1; a_addr_in_valid = 1'b1; settle;
    check("t2 accept 1", 32'(a_addr_in_ready), 1);
    step; a_addr_in = 32'h2; settle;
    check("t2 accept 2", 32'(a_addr_in_ready), 1);
    check("t2 addr_out 1", a_addr_out, 32'h1);
    step; a_addr_in = 32'h3; settle;
    check("t2 credit stall", 32'(a_addr_in_ready), 0);
    check("t2 addr_out 2", a_addr_out, 32'h2);
    step; a_mem_data = 32'hA; a_mem_valid = 1'b1; settle;
    check("t2 still stalled", 32'(a_addr_in_ready), 0);
    step; a_mem_data = 32'hB; settle;
    check("t2 mem_ready B", 32'(a_mem_ready), 1);
    check("t2 head A", a_data_out, 32'hA);
    step; a_mem_valid = 1'b0; a_data_out_ready = 1'b1; settle;
    check("t2 fifo full", 32'(a_mem_ready), 0);
    check("t2 no credit bypass", 32'(a_addr_in_ready), 0);
    check("t2 pop A", a_data_out, 32'hA);
    step; a_data_out_ready = 1'b0; settle;
    check("t2 credit freed", 32'(a_addr_in_ready), 1);
    check("t2 head B", a_data_out, 32'hB);
    step; a_addr_in_valid = 1'b0; settle;
    check("t2 addr_out 3 valid", 32'(a_addr_out_valid), 1);
    check("t2 addr_out 3", a_addr_out, 32'h3);
    step; a_mem_data = 32'hC; a_mem_valid = 1'b1; a_data_out_ready = 1'b1; settle;
    check("t2 mem_ready C", 32'(a_mem_ready), 1);
    check("t2 pop B", a_data_out, 32'hB);
    step; a_mem_valid = 1'b0; settle;
    check("t2 pop C", a_data_out, 32'hC);
    step; a_data_out_ready = 1'b0; settle;
    check("t2 drained", 32'(a_data_out_valid), 0);

    // ---- address back-pressure ----
    a_addr_out_ready = 1'b0;
    step; a_addr_in = 32'h20; a_addr_in_valid = 1'b1; settle;
    check("t3 accept 20", 32'(a_addr_in_ready), 1);
    step; a_addr_in = 32'h24;
    for (int i = 0; i < 3; i++) begin
      settle;
      check("t3 hold addr", a_addr_out, 32'h20);
      check("t3 hold valid", 32'(a_addr_out_valid), 1);
      check("t3 in blocked", 32'(a_addr_in_ready), 0);
      step;
    end
    a_addr_out_ready = 1'b1; settle;
    check("t3 release accept", 32'(a_addr_in_ready), 1);
    check("t3 release addr", a_addr_out, 32'h20);
    step; a_addr_in_valid = 1'b0; settle;
    check("t3 addr_out 24", a_addr_out, 32'h24);
    check("t3 addr_out 24 valid", 32'(a_addr_out_valid), 1);
    step; a_mem_data = 32'h200; a_mem_valid = 1'b1; a_data_out_ready = 1'b1; settle;
    step; a_mem_data = 32'h240; settle;
    check("t3 data 200", a_data_out, 32'h200);
    step; a_mem_valid = 1'b0; settle;
    check("t3 data 240", a_data_out, 32'h240);
    step; a_data_out_ready = 1'b0; settle;
    check("t3 drained", 32'(a_data_out_valid), 0);

    // ---- streaming with 1-cycle memory latency ----
    issued = 0; results = 0; window = 0; nxt = 32'h100;
    mem_q.delete(); exp_q.delete();
    step;
    for (int cyc = 0; cyc < 60; cyc++) begin
      a_addr_in_valid  = (cyc < 40);
      a_addr_in        = nxt;
      a_mem_valid      = (mem_q.size() > 0);
      a_mem_data       = (mem_q.size() > 0) ? mem_q[0] : 32'h0;
      a_data_out_ready = 1'b1;
      settle;
      if (a_mem_valid) begin
        check("t5 mem not blocked", 32'(a_mem_ready), 1);
        if (a_mem_ready) void'(mem_q.pop_front());
      end
      if (a_addr_out_valid && a_addr_out_ready) mem_q.push_back(a_addr_out * 7 + 1);
      if (a_addr_in_valid && a_addr_in_ready) begin
        exp_q.push_back(nxt * 7 + 1);
        nxt = nxt + 1;
        issued++;
      end
      if (a_data_out_valid) begin
        results++;
        if (cyc >= 10 && cyc < 30) window++;
        if (exp_q.size() == 0) check("t5 unexpected result", 32'(a_data_out_valid), 0);
        else check("t5 data", a_data_out, exp_q.pop_front());
      end
      step;
    end
    a_addr_in_valid = 1'b0; a_mem_valid = 1'b0; a_data_out_ready = 1'b0;
    check("t5 issued", issued, 20);
    check("t5 all returned", results, issued);
    check("t5 rate 1 per 2", window, 10);

    // ---- reset mid-operation ----
    a_addr_in = 32'h40; a_addr_in_valid = 1'b1; settle;
    check("t6 accept 40", 32'(a_addr_in_ready), 1);
    step; a_addr_in = 32'h44; settle;
    step; a_addr_in_valid = 1'b0; a_mem_data = 32'h400; a_mem_valid = 1'b1; settle;
    check("t6 mem_ready", 32'(a_mem_ready), 1);
    step; a_mem_valid = 1'b0; rst = 1'b1; settle;
    check("t6 fifo had data", 32'(a_data_out_valid), 1);
    check("t6 in_ready in rst", 32'(a_addr_in_ready), 0);
    check("t6 mem_ready in rst", 32'(a_mem_ready), 0);
    step; rst = 1'b0; settle;
    check("t6 addr_out_valid", 32'(a_addr_out_valid), 0);
    check("t6 data_out_valid", 32'(a_data_out_valid), 0);
    check("t6 addr_out", a_addr_out, 0);
    check("t6 data_out", a_data_out, 0);
    check("t6 in_ready", 32'(a_addr_in_ready), 1);
    check("t6 mem_ready after", 32'(a_mem_ready), 1);
    a_addr_in = 32'h50; a_addr_in_valid = 1'b1;
    step; a_addr_in_valid = 1'b0; settle;
    check("t6 addr_out 50", a_addr_out, 32'h50);
    check("t6 addr_out 50 valid", 32'(a_addr_out_valid), 1);
    step; a_mem_data = 32'h500; a_mem_valid = 1'b1; settle;
    step; a_mem_valid = 1'b0; a_data_out_ready = 1'b1; settle;
    check("t6 data 500 valid", 32'(a_data_out_valid), 1);
    check("t6 data 500", a_data_out, 32'h500);
    step; a_data_out_ready = 1'b0; settle;
    check("t6 drained", 32'(a_data_out_valid), 0);

    // ---- wrap-around, three slots, random result back-pressure ----
    sent = 0; got = 0;
    mem_q.delete();
    step;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      b_addr_in_valid  = (sent < 10);
      b_addr_in        = 32'(sent);
      b_mem_valid      = (mem_q.size() > 0);
      b_mem_data       = (mem_q.size() > 0) ? mem_q[0] : 32'h0;
      b_data_out_ready = 1'($urandom_range(0, 1));
      settle;
      if (b_mem_valid && b_mem_ready) void'(mem_q.pop_front());
      if (b_addr_out_valid && b_addr_out_ready) mem_q.push_back(b_addr_out * 3);
      if (b_addr_in_valid && b_addr_in_ready) sent++;
      if (b_data_out_valid && b_data_out_ready) begin
        check("t4 order", b_data_out, 32'(got * 3));
        got++;
      end
      step;
    end
    b_addr_in_valid = 1'b0; b_mem_valid = 1'b0; b_data_out_ready = 1'b0;
    check("t4 count", got, 10);
    settle;
    check("t4 drained", 32'(b_data_out_valid), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
